// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, registers big-endian instructions into IF/ID,
// and halts on misaligned or past-end PCs. Define FETCH_PERF_EN to add the perf_fetched counter.
module fetch_unit #(
   parameter logic [15:0] RESET_PC  = 16'd0,
   parameter int          MEM_BYTES = 100,
   parameter logic [15:0] NOP_INS   = 16'h0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic [15:0] pcout,
   input  logic [15:0] insin,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [15:0] branch_target,
   output logic [15:0] if_ins,
   output logic [15:0] if_pc,
   output logic        if_valid,
   output logic        halt,
   output logic        fault
`ifdef FETCH_PERF_EN
   ,
   output logic [15:0] perf_fetched
`endif
);

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   state_t      state;
   logic [15:0] pc;
   logic        past_end;
   logic        issue;

   assign pcout = pc;

   // Zero-extend to 32 bits so MEM_BYTES values near 64K still compare correctly.
   assign past_end = 32'(pc) > 32'(MEM_BYTES - 2);

   assign issue = (state == ST_RUN) && !branch_taken && !pc[0] && !past_end && !stall;

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_BOOT;
         pc       <= RESET_PC;
         if_ins   <= NOP_INS;
         if_pc    <= 16'd0;
         if_valid <= 1'b0;
         halt     <= 1'b0;
         fault    <= 1'b0;
      end else begin
         case (state)
            ST_BOOT: begin
               if_valid <= 1'b0;
               state    <= ST_RUN;
            end
            ST_RUN: begin
               if (branch_taken) begin
                  // Redirect wins over stall; the wrong-path fetch becomes a bubble.
                  pc       <= branch_target;
                  if_ins   <= NOP_INS;
                  if_valid <= 1'b0;
               end else if (pc[0]) begin
                  state    <= ST_HALT;
                  halt     <= 1'b1;
                  fault    <= 1'b1;
                  if_valid <= 1'b0;
               end else if (past_end) begin
                  state    <= ST_HALT;
                  halt     <= 1'b1;
                  fault    <= 1'b0;
                  if_valid <= 1'b0;
               end else if (issue) begin
                  if_ins   <= insin;
                  if_pc    <= pc;
                  if_valid <= 1'b1;
                  pc       <= pc + 16'd2;
               end
            end
            ST_HALT: begin
               if_valid <= 1'b0;
            end
            default: begin
               state    <= ST_BOOT;
               if_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef FETCH_PERF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_fetched <= 16'd0;
      end else if (issue && (perf_fetched != 16'hFFFF)) begin
         perf_fetched <= perf_fetched + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the fetch rules.
module tb_fetch_unit;

   localparam int          MEM_BYTES = 100;
   localparam logic [15:0] NOP_INS   = 16'h0000;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] pcout;
   logic [15:0] insin;
   logic        stall;
   logic        branch_taken;
   logic [15:0] branch_target;
   logic [15:0] if_ins;
   logic [15:0] if_pc;
   logic        if_valid;
   logic        halt;
   logic        fault;
`ifdef FETCH_PERF_EN
   logic [15:0] perf_fetched;
`endif

   int checks = 0;
   int errors = 0;

   logic [7:0] mem [0:MEM_BYTES-1];

   // Reference model state.
   logic [15:0] m_pc;
   bit          m_boot;
   bit          m_halt;
   bit          m_fault;
   logic [15:0] m_ins;
   logic [15:0] m_ipc;
   bit          m_valid;
   int          m_perf;

   always #5 clk = ~clk;

   fetch_unit #(
      .RESET_PC (16'd0),
      .MEM_BYTES(MEM_BYTES),
      .NOP_INS  (NOP_INS)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .pcout        (pcout),
      .insin        (insin),
      .stall        (stall),
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .if_ins       (if_ins),
      .if_pc        (if_pc),
      .if_valid     (if_valid),
      .halt         (halt),
      .fault        (fault)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetched (perf_fetched)
`endif
   );

   function automatic logic [15:0] word_at(int a);
      if (a >= 0 && a + 1 < MEM_BYTES) return {mem[a], mem[a+1]};
      return 16'hDEAD;
   endfunction

   // Combinational instruction memory, big-endian.
   always_comb insin = word_at(int'(pcout));

   // Applies the fetch rules for one rising edge using the inputs as sampled.
   task automatic model_edge();
      if (reset) begin
         m_pc = 16'd0; m_boot = 1; m_halt = 0; m_fault = 0;
         m_ins = NOP_INS; m_ipc = 16'd0; m_valid = 0; m_perf = 0;
      end else if (m_halt) begin
         m_valid = 0;
      end else if (m_boot) begin
         m_boot = 0; m_valid = 0;
      end else if (branch_taken) begin
         m_pc = branch_target; m_ins = NOP_INS; m_valid = 0;
      end else if (m_pc % 2 == 1) begin
         m_halt = 1; m_fault = 1; m_valid = 0;
      end else if (int'(m_pc) > MEM_BYTES - 2) begin
         m_halt = 1; m_fault = 0; m_valid = 0;
      end else if (!stall) begin
         m_ins = word_at(int'(m_pc)); m_ipc = m_pc; m_valid = 1;
         m_pc = m_pc + 16'd2;
         if (m_perf < 65535) m_perf = m_perf + 1;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic drive(input logic s, input logic b, input logic [15:0] t);
      stall = s; branch_taken = b; branch_target = t;
   endtask

   task automatic do_reset();
      reset = 1'b1; drive(0, 0, 16'd0);
      step(); step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({pcout, if_ins, if_pc, if_valid, halt, fault} !== {16'd0, NOP_INS, 16'd0, 3'b000}) begin
         errors++;
         $display("FAIL reset_state: got pc=%h ins=%h ipc=%h v=%b h=%b f=%b, want all zero",
                  pcout, if_ins, if_pc, if_valid, halt, fault);
      end
   endtask

   task automatic test_standard_program();
      logic [15:0] exp_ins [0:2];
      exp_ins[0] = 16'h5320; exp_ins[1] = 16'h5C20; exp_ins[2] = 16'h64A0;
      step();
      checks++;
      if (if_valid !== 1'b0 || pcout !== 16'd0) begin
         errors++;
         $display("FAIL boot_cycle: got v=%b pc=%h, want v=0 pc=0000", if_valid, pcout);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (if_ins !== exp_ins[i] || if_pc !== 16'(2 * i) || if_valid !== 1'b1) begin
            errors++;
            $display("FAIL issue_%0d: got ins=%h pc=%h v=%b, want ins=%h pc=%h v=1",
                     i, if_ins, if_pc, if_valid, exp_ins[i], 16'(2 * i));
         end
      end
   endtask

   task automatic test_stall();
      drive(1, 0, 16'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (if_ins !== 16'h64A0 || if_pc !== 16'd4 || pcout !== 16'd6 || if_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold_%0d: got ins=%h ipc=%h pc=%h v=%b, want ins=64a0 ipc=0004 pc=0006 v=1",
                     i, if_ins, if_pc, pcout, if_valid);
         end
      end
      drive(0, 0, 16'd0);
      step();
      checks++;
      if (if_ins !== 16'hCC04 || if_pc !== 16'd6 || if_valid !== 1'b1) begin
         errors++;
         $display("FAIL stall_release: got ins=%h ipc=%h v=%b, want ins=cc04 ipc=0006 v=1",
                  if_ins, if_pc, if_valid);
      end
`ifdef FETCH_PERF_EN
      checks++;
      if (perf_fetched !== 16'd4) begin
         errors++;
         $display("FAIL perf_after_stall: got %0d, want 4", perf_fetched);
      end
`endif
   endtask

   task automatic test_branch(input logic with_stall);
      drive(with_stall, 1, 16'd12);
      step();
      checks++;
      if (if_valid !== 1'b0 || pcout !== 16'd12 || if_ins !== NOP_INS) begin
         errors++;
         $display("FAIL branch_bubble(stall=%0b): got v=%b pc=%h ins=%h, want v=0 pc=000c ins=%h",
                  with_stall, if_valid, pcout, if_ins, NOP_INS);
      end
      drive(0, 0, 16'd0);
      step();
      checks++;
      if (if_valid !== 1'b1 || if_pc !== 16'd12 || if_ins !== word_at(12)) begin
         errors++;
         $display("FAIL branch_target(stall=%0b): got v=%b ipc=%h ins=%h, want v=1 ipc=000c ins=%h",
                  with_stall, if_valid, if_pc, if_ins, word_at(12));
      end
   endtask

   task automatic test_misaligned();
      drive(0, 1, 16'd13);
      step();
      drive(0, 0, 16'd0);
      checks++;
      if (pcout !== 16'd13 || halt !== 1'b0) begin
         errors++;
         $display("FAIL odd_accept: got pc=%h h=%b, want pc=000d h=0", pcout, halt);
      end
      step();
      checks++;
      if (halt !== 1'b1 || fault !== 1'b1 || if_valid !== 1'b0) begin
         errors++;
         $display("FAIL odd_halt: got h=%b f=%b v=%b, want h=1 f=1 v=0", halt, fault, if_valid);
      end
      for (int i = 0; i < 4; i++) begin
         drive(i[0], 1, 16'd20);
         step();
         checks++;
         if (pcout !== 16'd13 || halt !== 1'b1 || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL odd_frozen_%0d: got pc=%h h=%b v=%b, want pc=000d h=1 v=0",
                     i, pcout, halt, if_valid);
         end
      end
      drive(0, 0, 16'd0);
   endtask

   task automatic test_end_of_memory();
      int last_pc = -1;
      int budget  = 0;
      do_reset();
      while (halt !== 1'b1 && budget < 200) begin
         step();
         budget++;
         if (if_valid === 1'b1) last_pc = int'(if_pc);
      end
      checks++;
      if (halt !== 1'b1) begin
         errors++;
         $display("FAIL eom_timeout: halt=%b after %0d cycles, want halt=1", halt, budget);
      end
      checks++;
      if (last_pc != MEM_BYTES - 2 || fault !== 1'b0 || pcout !== 16'(MEM_BYTES)) begin
         errors++;
         $display("FAIL eom_halt: got last_ipc=%0d f=%b pc=%0d, want last_ipc=%0d f=0 pc=%0d",
                  last_pc, fault, pcout, MEM_BYTES - 2, MEM_BYTES);
      end
      drive(1, 1, 16'd4);
      step(); step();
      drive(0, 0, 16'd0);
      checks++;
      if (pcout !== 16'(MEM_BYTES) || halt !== 1'b1) begin
         errors++;
         $display("FAIL eom_held: got pc=%0d h=%b, want pc=%0d h=1", pcout, halt, MEM_BYTES);
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++;
      if ({pcout, if_ins, if_pc, if_valid, halt, fault} !== {16'd0, NOP_INS, 16'd0, 3'b000}) begin
         errors++;
         $display("FAIL reset_mid_halt: got pc=%h ins=%h ipc=%h v=%b h=%b f=%b, want all zero",
                  pcout, if_ins, if_pc, if_valid, halt, fault);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 600; i++) begin
         reset = ($urandom_range(0, 99) < 2) || (m_halt && $urandom_range(0, 99) < 20);
         stall = ($urandom_range(0, 99) < 25);
         branch_taken = ($urandom_range(0, 99) < 10);
         if ($urandom_range(0, 9) < 8) branch_target = 16'($urandom_range(0, 49) * 2);
         else                          branch_target = 16'($urandom_range(0, 120));
         step();
         checks++;
         if ({pcout, if_ins, if_pc, if_valid, halt, fault} !==
             {m_pc, m_ins, m_ipc, m_valid, m_halt, m_fault}) begin
            errors++;
            $display("FAIL random_%0d: got pc=%h ins=%h ipc=%h v=%b h=%b f=%b, want pc=%h ins=%h ipc=%h v=%b h=%b f=%b",
                     i, pcout, if_ins, if_pc, if_valid, halt, fault,
                     m_pc, m_ins, m_ipc, m_valid, m_halt, m_fault);
         end
`ifdef FETCH_PERF_EN
         checks++;
         if (int'(perf_fetched) != m_perf) begin
            errors++;
            $display("FAIL random_perf_%0d: got %0d, want %0d", i, perf_fetched, m_perf);
         end
`endif
      end
      reset = 1'b0;
      drive(0, 0, 16'd0);
   endtask

`ifdef FETCH_PERF_EN
   task automatic test_perf_saturation();
      int issued = 0;
      int budget = 0;
      do_reset();
      while (issued < 70000 && budget < 90000) begin
         drive(0, (m_pc == 16'd90), 16'd0);
         step();
         budget++;
         if (if_valid === 1'b1 && !branch_taken) issued++;
      end
      drive(0, 0, 16'd0);
      checks++;
      if (issued < 70000 || perf_fetched !== 16'hFFFF) begin
         errors++;
         $display("FAIL perf_saturate: got %h after %0d issues, want ffff after 70000", perf_fetched, issued);
      end
   endtask
`endif

   initial begin
      reset = 1'b1;
      drive(0, 0, 16'd0);
      for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'($urandom);
      {mem[0], mem[1]} = 16'h5320;
      {mem[2], mem[3]} = 16'h5C20;
      {mem[4], mem[5]} = 16'h64A0;
      {mem[6], mem[7]} = 16'hCC04;
      m_pc = 0; m_boot = 1; m_halt = 0; m_fault = 0;
      m_ins = NOP_INS; m_ipc = 0; m_valid = 0; m_perf = 0;
      #1;
      test_reset();
      test_standard_program();
      test_stall();
      test_branch(1'b0);
      test_branch(1'b1);
      test_misaligned();
      test_end_of_memory();
      test_random();
`ifdef FETCH_PERF_EN
      test_perf_saturation();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
